// File: rtl/dds_phase_gen_if.sv
// Bundles the selector-facing request signals and the phase
// generator outputs so that both ends can share one connection.
interface dds_phase_gen_if #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 10
);
    logic [10:0]      address;
    logic             FreqChng;
    logic             Enable;
    logic [OUT_W-1:0] phase_out;
    logic             wrap;
    logic             busy;
    logic [ACC_W-1:0] ftw;

    // Upstream side: issues frequency requests and the run enable.
    modport master (
        output address, FreqChng, Enable,
        input  phase_out, wrap, busy, ftw
    );

    // Phase generator side.
    modport slave (
        input  address, FreqChng, Enable,
        output phase_out, wrap, busy, ftw
    );
endinterface

// File: rtl/dds_phase_gen.sv
// DDS phase generator: converts a frequency index into a tuning word
// with an 11-step shift-add multiply, then applies it to the phase
// accumulator only when the accumulator wraps, so the generated
// waveform never jumps in phase when the frequency changes.
module dds_phase_gen #(
    parameter int ACC_W  = 32,
    parameter int K_MULT = 429,
    parameter int OUT_W  = 10
) (
    input  logic           Fg_clk,
    input  logic           Reset,
    dds_phase_gen_if.slave bus
);
    localparam int PROD_W = 27;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        ARM
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [10:0]         mcand_q;
    logic [PROD_W-1:0]   prod_q;
    logic [3:0]          bit_cnt_q;
    logic [10:0]         pend_addr_q;
    logic                pend_valid_q;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    ftw_q;
    logic                wrap_q;
    logic                busy_q;

    logic                start;
    logic                commit;
    logic                carry;
    logic                commit_ok;
    logic [ACC_W:0]      acc_sum;
    logic [PROD_W-1:0]   k_shifted;

    assign acc_sum   = {1'b0, acc_q} + {1'b0, ftw_q};
    assign carry     = acc_sum[ACC_W];
    assign k_shifted = PROD_W'(K_MULT) << bit_cnt_q;
    // A new word may land when the output is idle, silent, or wrapping.
    assign commit_ok = !bus.Enable || (ftw_q == '0) || carry;

    // Next-state and control decode; a live strobe beats a queued one.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.FreqChng || pend_valid_q) begin
                    start   = 1'b1;
                    state_d = MULT;
                end
            end
            MULT: begin
                if (bit_cnt_q == 4'd10) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (commit_ok) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Fg_clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Shift-add multiplier and the single-entry request queue.
    always_ff @(posedge Fg_clk) begin
        if (Reset) begin
            mcand_q      <= '0;
            prod_q       <= '0;
            bit_cnt_q    <= '0;
            pend_addr_q  <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            if (start) begin
                mcand_q   <= bus.FreqChng ? bus.address : pend_addr_q;
                prod_q    <= '0;
                bit_cnt_q <= '0;
            end else if (state_q == MULT) begin
                if (mcand_q[bit_cnt_q]) begin
                    prod_q <= prod_q + k_shifted;
                end
                bit_cnt_q <= bit_cnt_q + 4'd1;
            end

            if ((state_q != IDLE) && bus.FreqChng) begin
                pend_addr_q  <= bus.address;
                pend_valid_q <= 1'b1;
            end else if (start) begin
                pend_valid_q <= 1'b0;
            end
        end
    end

    // Applied tuning word, replaced only on an allowed commit edge.
    always_ff @(posedge Fg_clk) begin
        if (Reset) begin
            ftw_q <= '0;
        end else if (commit) begin
            ftw_q <= ACC_W'(prod_q);
        end
    end

    // Phase accumulator and its carry-out pulse.
    always_ff @(posedge Fg_clk) begin
        if (Reset) begin
            acc_q  <= '0;
            wrap_q <= 1'b0;
        end else if (bus.Enable) begin
            acc_q  <= acc_sum[ACC_W-1:0];
            wrap_q <= carry;
        end else begin
            acc_q  <= '0;
            wrap_q <= 1'b0;
        end
    end

    // Busy lags the state by one edge so it covers the commit edge.
    always_ff @(posedge Fg_clk) begin
        if (Reset) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= (state_q != IDLE);
        end
    end

    assign bus.phase_out = acc_q[ACC_W-1 -: OUT_W];
    assign bus.wrap      = wrap_q;
    assign bus.busy      = busy_q;
    assign bus.ftw       = ftw_q;
endmodule

// File: tb/tb_dds_phase_gen.sv
// Directed bench for dds_phase_gen: a table of index -> tuning word
// conversions plus hand-built sequences for wrap-aligned commits,
// queued requests and reset during a conversion.
module tb_dds_phase_gen;
    logic Fg_clk;
    logic Reset;

    int check_count = 0;
    int pass_count  = 0;

    dds_phase_gen_if #(.ACC_W(32), .OUT_W(10)) bus ();

    dds_phase_gen #(.ACC_W(32), .K_MULT(429), .OUT_W(10)) dut (
        .Fg_clk (Fg_clk),
        .Reset  (Reset),
        .bus    (bus)
    );

    // Free-running clock.
    initial begin
        Fg_clk = 1'b0;
        forever #5 Fg_clk = ~Fg_clk;
    end

    typedef struct {
        logic [10:0] addr;
        logic [31:0] exp_ftw;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge Fg_clk);
        @(negedge Fg_clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One-cycle request strobe; returns just after the accepting edge.
    task automatic applyStimulus(input logic [10:0] addr);
        bus.address  = addr;
        bus.FreqChng = 1'b1;
        tick();
        bus.FreqChng = 1'b0;
    endtask

    task automatic doReset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        logic [31:0] prev_ftw;
        int          cnt;
        logic        found;

        Reset        = 1'b1;
        bus.address  = '0;
        bus.FreqChng = 1'b0;
        bus.Enable   = 1'b0;
        tick();
        tick();
        checkOutput("reset_phase", 32'(bus.phase_out), 32'd0);
        checkOutput("reset_wrap",  32'(bus.wrap),      32'd0);
        checkOutput("reset_busy",  32'(bus.busy),      32'd0);
        checkOutput("reset_ftw",   bus.ftw,            32'd0);
        Reset = 1'b0;

        vecs[0] = '{11'd100,  32'd42900};
        vecs[1] = '{11'd1,    32'd429};
        vecs[2] = '{11'd1800, 32'd772200};
        vecs[3] = '{11'd2047, 32'd878163};
        vecs[4] = '{11'd0,    32'd0};
        vecs[5] = '{11'd1365, 32'd585585};
        vecs[6] = '{11'd682,  32'd292578};
        vecs[7] = '{11'd1024, 32'd439296};

        // Conversions with Enable low: commit lands exactly twelve edges on.
        prev_ftw = 32'd0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].addr);
            checkOutput("busy_e0", 32'(bus.busy), 32'd0);
            for (int k = 1; k <= 12; k++) begin
                tick();
                checkOutput("busy_run", 32'(bus.busy), 32'd1);
                if (k == 11) checkOutput("ftw_hold_e11", bus.ftw, prev_ftw);
            end
            checkOutput("ftw_e12", bus.ftw, vecs[i].exp_ftw);
            checkOutput("phase_idle", 32'(bus.phase_out), 32'd0);
            tick();
            checkOutput("busy_e13", 32'(bus.busy), 32'd0);
            prev_ftw = vecs[i].exp_ftw;
        end

        // Running from ftw=0: immediate commit, then count to the first wrap.
        doReset();
        bus.Enable = 1'b1;
        applyStimulus(11'd1800);
        for (int k = 1; k <= 12; k++) tick();
        checkOutput("run_ftw", bus.ftw, 32'd772200);
        cnt = 0;
        while (!bus.wrap && cnt < 20000) begin
            tick();
            cnt++;
            if (cnt == 6) checkOutput("run_phase6", 32'(bus.phase_out), 32'd1);
        end
        checkOutput("first_wrap_cycles", 32'(cnt), 32'd5562);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!bus.wrap && cnt < 20000);
        checkOutput("wrap_period_ok", 32'(cnt == 5561 || cnt == 5562), 32'd1);

        // Index 0 while running: ftw drops to 0 on the wrap edge, then freezes.
        applyStimulus(11'd0);
        found = 1'b0;
        for (int k = 0; k < 12000 && !found; k++) begin
            tick();
            if (bus.ftw != 32'd772200) found = 1'b1;
        end
        checkOutput("zero_commit_seen", 32'(found), 32'd1);
        checkOutput("zero_commit_wrap", 32'(bus.wrap), 32'd1);
        checkOutput("zero_commit_ftw",  bus.ftw, 32'd0);
        for (int k = 0; k < 20; k++) tick();
        checkOutput("frozen_wrap",  32'(bus.wrap), 32'd0);
        checkOutput("frozen_phase", 32'(bus.phase_out), 32'd0);

        // Back to 772200 (ftw=0 allows immediate commit), then request index 1.
        applyStimulus(11'd1800);
        for (int k = 1; k <= 11; k++) tick();
        checkOutput("restart_hold", bus.ftw, 32'd0);
        tick();
        checkOutput("restart_ftw", bus.ftw, 32'd772200);
        applyStimulus(11'd1);
        found = 1'b0;
        cnt = 0;
        for (int k = 0; k < 12000 && !found; k++) begin
            tick();
            cnt++;
            if (bus.ftw != 32'd772200) found = 1'b1;
        end
        checkOutput("slow_commit_seen",  32'(found), 32'd1);
        checkOutput("slow_commit_late",  32'(cnt >= 11), 32'd1);
        checkOutput("slow_commit_wrap",  32'(bus.wrap), 32'd1);
        checkOutput("slow_commit_ftw",   bus.ftw, 32'd429);
        checkOutput("slow_commit_phase", 32'(bus.phase_out), 32'd0);

        // Second request queued mid-multiply (bit_cnt=4 edge).
        bus.Enable = 1'b0;
        tick();
        applyStimulus(11'd10);
        for (int k = 1; k <= 4; k++) tick();
        applyStimulus(11'd20);
        for (int k = 6; k <= 12; k++) tick();
        checkOutput("queue_first_ftw",  bus.ftw, 32'd4290);
        checkOutput("queue_busy_e12",   32'(bus.busy), 32'd1);
        tick();
        checkOutput("queue_busy_e13",   32'(bus.busy), 32'd0);
        tick();
        checkOutput("queue_busy_e14",   32'(bus.busy), 32'd1);
        for (int k = 15; k <= 24; k++) tick();
        checkOutput("queue_hold_e24",   bus.ftw, 32'd4290);
        tick();
        checkOutput("queue_second_ftw", bus.ftw, 32'd8580);
        tick();
        checkOutput("queue_busy_done",  32'(bus.busy), 32'd0);

        // Reset on the bit_cnt=6 edge aborts the conversion for good.
        applyStimulus(11'd1800);
        for (int k = 1; k <= 6; k++) tick();
        doReset();
        checkOutput("abort_busy",  32'(bus.busy), 32'd0);
        checkOutput("abort_ftw",   bus.ftw, 32'd0);
        checkOutput("abort_phase", 32'(bus.phase_out), 32'd0);
        for (int k = 0; k < 30; k++) tick();
        checkOutput("abort_no_commit", bus.ftw, 32'd0);
        checkOutput("abort_idle",      32'(bus.busy), 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
